inst_decode_stage: RTL and testbench
====================================

Name: inst_decode_stage

Overview:
Buffered, handshaked RV32I decode stage between fetch and register read/execute. Accepts raw instructions with their PC on a valid/ready interface and decodes every RV32I format, including correct B-type immediates, shift-immediate checks, SYSTEM and FENCE. Results are held in a DEPTH-entry decoded-instruction queue, so fetch and execute stall independently. Adds an illegal-instruction flag, register-use and write-enable flags, and a pipeline flush.

Parameters:
XLEN, 32, datapath width for PC and immediate; instruction width fixed at 32
DEPTH, 4, decoded-entry queue depth; power of two, >= 2
PTR_W, $clog2(DEPTH), derived pointer width; do not override

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous queue clear (branch mispredict / trap)
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept this cycle
in_inst  input  32  raw instruction
in_pc  input  XLEN  instruction PC
out_valid  output  1  head entry valid
out_ready  input  1  consumer takes head entry
out_pc  output  XLEN  head PC
out_op  output  7  opcode
out_funct3  output  3  funct3
out_funct7  output  7  funct7
out_rd / out_rs1 / out_rs2  output  5 each  register indices
out_imm  output  XLEN  sign- or zero-extended immediate
out_rd_we  output  1  writes rd (forced 0 when rd==x0)
out_rs1_used / out_rs2_used  output  1 each  source read required
out_illegal  output  1  unrecognised encoding

Behaviour:
- Reset (async, any cycle): wr_ptr, rd_ptr and count=0; out_valid=0; in_ready=1. Queue RAM need not reset.
- Every out_* data field reads 0 whenever out_valid=0; never X.
- Push: in_valid && in_ready at edge N; the decoded entry is visible at out_* from N+1 (1-cycle latency). No combinational in-to-out path.
- Pop: out_valid && out_ready at an edge advances rd_ptr.
- in_ready = (count < DEPTH). It does not depend on out_ready. When full, a same-cycle pop does not allow a push.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is PTR_W+1 bits wide.
- flush: at the next edge, count, wr_ptr and rd_ptr go to 0. It overrides push and pop in that cycle, and the input presented that cycle is dropped. in_ready=1 in the following cycle.
- Decode rules:
  - R: rd, rs1, rs2 and funct7 are valid. funct7 must be 0x00, or 0x20 only for ADD/SUB and SRL/SRA; otherwise illegal.
  - I (OP_IMM, LOAD, JALR): imm = sext(inst[31:20]). For SLLI/SRLI/SRAI, funct7 must be 0x00, 0x20 only for SRAI, otherwise illegal. out_imm = zext(inst[24:20]).
  - S: imm = sext({inst[31:25], inst[11:7]}); rd_we=0.
  - B: imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); rd_we=0.
  - U (LUI, AUIPC): imm = {inst[31:12], 12'b0}.
  - J: imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - FENCE and SYSTEM (ECALL/EBREAK only): legal, all use flags 0.
  - LOAD funct3 must be in {0,1,2,4,5}; STORE funct3 must be in {0,1,2}; BRANCH funct3 must not be 2 or 3. Anything else is illegal.
  - Unused fields read 0. An illegal entry has all use/we flags 0 and imm=0, but still queues with its PC.

Optional Feature:
RV32M_DECODE_EN
- Defined: OP_R3 with funct7=0x01 is legal for all funct3 (MUL..REMU), with rd_we, rs1_used and rs2_used set.
- Undefined: funct7=0x01 is illegal.

Decomposition:
- Package decode_pkg holds:
  - opcode, funct3 and funct7 localparams;
  - imm_fmt_e enum {IMM_NONE, I, S, B, U, J};
  - decoded_inst_t packed struct holding all out_* fields except out_valid.
- Sub-module inst_decode_comb is purely combinational: in_inst and in_pc in, decoded_inst_t out.
- inst_decode_stage contains the queue, pointers and handshake.

Test Plan:
- Reset, then push 0xFFF00093 (addi x1,x0,-1) at PC 0x100 -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, rd_we=1, rs2_used=0, illegal=0.
- Push 0xFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFC, rs1=1, rs2=2, rd_we=0, rs1_used=rs2_used=1.
- out_ready=0; push 4 entries -> in_ready=0 after the 4th push and the 5th is held. Then out_ready=1 with in_valid=1 -> 4 entries drain in FIFO order and in_ready returns.
- 3 entries queued, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, flushed-cycle input absent. Async reset pulsed mid-stream -> same result immediately.
- Push 0x00000000 and 0x40001033 (funct7=0x20 on SLL) -> both out_illegal=1, rd_we=0, imm=0.
- Push 0x022081B3 (mul x3,x1,x2) -> illegal=1 without RV32M_DECODE_EN; illegal=0 and rd=3, rd_we=1 with it.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32I decode constants, immediate-format enum and the decoded-entry record.
// RV32M_DECODE_EN (in inst_decode_comb) additionally accepts the M-extension encodings.
package decode_pkg;

  localparam int DEC_XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP_R3  = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic [DEC_XLEN-1:0] pc;
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [DEC_XLEN-1:0] imm;
    logic                rd_we;
    logic                rs1_used;
    logic                rs2_used;
    logic                illegal;
  } decoded_inst_t;

endpackage

// File: rtl/inst_decode_comb.sv
// Purely combinational RV32I decoder: raw instruction + PC in, decoded record out.
// Define RV32M_DECODE_EN to accept MUL/DIV/REM (funct7=0x01) on the register-register opcode.
module inst_decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = DEC_XLEN
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output decoded_inst_t   dec
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_fmt_e   fmt;
  logic       legal, use_rd, use_rs1, use_rs2, keep_f3, keep_f7, shamt_imm;
  logic [XLEN-1:0] imm;

  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];

  always_comb begin
    fmt       = IMM_NONE;
    legal     = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    keep_f3   = 1'b0;
    keep_f7   = 1'b0;
    shamt_imm = 1'b0;
    case (op)
      OPC_LUI, OPC_AUIPC: begin
        legal = 1'b1; fmt = IMM_U; use_rd = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; fmt = IMM_J; use_rd = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'd0); fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; keep_f3 = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3);
        fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; keep_f3 = 1'b1;
      end
      OPC_LOAD: begin
        legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; keep_f3 = 1'b1;
      end
      OPC_STORE: begin
        legal = (f3 <= 3'd2);
        fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; keep_f3 = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; keep_f3 = 1'b1;
        // Shift-immediates reuse the funct7 slot, so it is both checked and passed on.
        if (f3 == F3_SLL) begin
          legal = (f7 == F7_BASE); shamt_imm = 1'b1; keep_f7 = 1'b1;
        end else if (f3 == F3_SRL_SRA) begin
          legal = (f7 == F7_BASE) || (f7 == F7_ALT); shamt_imm = 1'b1; keep_f7 = 1'b1;
        end else begin
          legal = 1'b1;
        end
      end
      OPC_OP_R3: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; keep_f3 = 1'b1; keep_f7 = 1'b1;
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
`ifdef RV32M_DECODE_EN
        if (f7 == F7_MULDIV) legal = 1'b1;
`else
        if (f7 == F7_MULDIV) legal = 1'b0;
`endif
      end
      OPC_FENCE: begin
        legal = (f3 == 3'd0); keep_f3 = 1'b1;
      end
      OPC_SYSTEM: begin
        // imm carries 0 for ECALL and 1 for EBREAK so execute can tell them apart.
        legal = (inst == INST_ECALL) || (inst == INST_EBREAK); fmt = IMM_I;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = XLEN'(signed'({inst[31:12], 12'b0}));
      IMM_J:   imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    if (shamt_imm) imm = XLEN'(inst[24:20]);
  end

  always_comb begin
    dec          = '0;
    dec.pc       = pc;
    dec.op       = op;
    dec.illegal  = !legal;
    if (legal) begin
      dec.funct3   = keep_f3 ? f3 : 3'd0;
      dec.funct7   = keep_f7 ? f7 : 7'd0;
      dec.rd       = use_rd  ? inst[11:7]  : 5'd0;
      dec.rs1      = use_rs1 ? inst[19:15] : 5'd0;
      dec.rs2      = use_rs2 ? inst[24:20] : 5'd0;
      dec.imm      = imm;
      dec.rd_we    = use_rd && (inst[11:7] != 5'd0);
      dec.rs1_used = use_rs1;
      dec.rs2_used = use_rs2;
    end
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Handshaked decode stage: decodes on accept and buffers results in a DEPTH-entry queue.
// RV32M_DECODE_EN is honoured by the inst_decode_comb sub-module.
module inst_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = DEC_XLEN,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_illegal
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  decoded_inst_t dec, head;
  decoded_inst_t mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  inst_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst (in_inst),
    .pc   (in_pc),
    .dec  (dec)
  );

  // Readiness looks only at occupancy, so a full queue never accepts on a same-cycle pop.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  // Gate the head so stale or never-written storage is not visible while empty.
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc       = head.pc;
  assign out_op       = head.op;
  assign out_funct3   = head.funct3;
  assign out_funct7   = head.funct7;
  assign out_rd       = head.rd;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_imm      = head.imm;
  assign out_rd_we    = head.rd_we;
  assign out_rs1_used = head.rs1_used;
  assign out_rs2_used = head.rs2_used;
  assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: vector table + scoreboard, plus backpressure, flush and reset sequences.
// Build with +define+RV32M_DECODE_EN to expect MUL to decode as legal.
module tb_inst_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [6:0]  out_op, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_rd_we, out_rs1_used, out_rs2_used, out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]   inst;
    decoded_inst_t exp;
  } vec_t;

  vec_t          vecs[$];
  decoded_inst_t sb[$];
  decoded_inst_t cur_exp;
  decoded_inst_t act;
  logic [31:0]   next_pc = 32'h100;

  inst_decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_rd_we(out_rd_we),
    .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    act          = '0;
    act.pc       = out_pc;
    act.op       = out_op;
    act.funct3   = out_funct3;
    act.funct7   = out_funct7;
    act.rd       = out_rd;
    act.rs1      = out_rs1;
    act.rs2      = out_rs2;
    act.imm      = out_imm;
    act.rd_we    = out_rd_we;
    act.rs1_used = out_rs1_used;
    act.rs2_used = out_rs2_used;
    act.illegal  = out_illegal;
  end

  function automatic decoded_inst_t mk(input int op, input int f3, input int f7, input int rd,
                                       input int rs1, input int rs2, input logic [31:0] imm,
                                       input int we, input int u1, input int u2, input int ill);
    decoded_inst_t e;
    e          = '0;
    e.op       = 7'(op);
    e.funct3   = 3'(f3);
    e.funct7   = 7'(f7);
    e.rd       = 5'(rd);
    e.rs1      = 5'(rs1);
    e.rs2      = 5'(rs2);
    e.imm      = imm;
    e.rd_we    = 1'(we);
    e.rs1_used = 1'(u1);
    e.rs2_used = 1'(u2);
    e.illegal  = 1'(ill);
    return e;
  endfunction

  function automatic void add_vec(input logic [31:0] inst, input decoded_inst_t e);
    vec_t v;
    v.inst = inst;
    v.exp  = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Scoreboard: expectations queued on accepted pushes, compared on pops.
  always @(negedge clk or posedge reset) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h, want nothing", act);
        end else begin
          if (act !== sb[0]) begin
            errors++;
            $display("FAIL entry_pc_%h: got %h, want %h", sb[0].pc, act, sb[0]);
          end else begin
            $display("pop pc=%h op=%h rd=%0d imm=%h illegal=%b", act.pc, act.op, act.rd, act.imm, act.illegal);
          end
          void'(sb.pop_front());
        end
      end
      if (!out_valid) begin
        checks++;
        if (act !== '0) begin
          errors++;
          $display("FAIL idle_zero: got %h, want 0", act);
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic push_one(input vec_t v);
    decoded_inst_t e;
    int            n;
    logic          done;
    e        = v.exp;
    e.pc     = next_pc;
    in_inst  = v.inst;
    in_pc    = next_pc;
    cur_exp  = e;
    in_valid = 1'b1;
    next_pc  = next_pc + 32'd4;
    done     = 1'b0;
    n        = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 128'(done), 128'(1'b1));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 128'(out_valid), 128'(1'b0));
    check({name, "_sb_empty"}, 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0; cur_exp = '0;

    add_vec(32'hFFF00093, mk(7'h13, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 1, 1, 0, 0)); // addi x1,x0,-1
    add_vec(32'hFE208EE3, mk(7'h63, 0, 0, 0, 1, 2, 32'hFFFFFFFC, 0, 1, 1, 0)); // beq x1,x2,-4
    add_vec(32'h002081B3, mk(7'h33, 0, 0, 3, 1, 2, 32'h0, 1, 1, 1, 0));        // add
    add_vec(32'h407302B3, mk(7'h33, 0, 7'h20, 5, 6, 7, 32'h0, 1, 1, 1, 0));    // sub
    add_vec(32'h40001033, mk(7'h33, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));        // sll with funct7=0x20
    add_vec(32'h00000000, mk(7'h00, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));        // all zero
    add_vec(32'h0105A503, mk(7'h03, 2, 0, 10, 11, 0, 32'h10, 1, 1, 0, 0));     // lw x10,16(x11)
    add_vec(32'h0105B503, mk(7'h03, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));        // load funct3=3
    add_vec(32'hFEC12E23, mk(7'h23, 2, 0, 0, 2, 12, 32'hFFFFFFFC, 0, 1, 1, 0)); // sw x12,-4(x2)
    add_vec(32'hFE20AEE3, mk(7'h63, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));        // branch funct3=2
    add_vec(32'h123457B7, mk(7'h37, 0, 0, 15, 0, 0, 32'h12345000, 1, 0, 0, 0)); // lui
    add_vec(32'h80000117, mk(7'h17, 0, 0, 2, 0, 0, 32'h80000000, 1, 0, 0, 0)); // auipc
    add_vec(32'h008000EF, mk(7'h6F, 0, 0, 1, 0, 0, 32'h8, 1, 0, 0, 0));        // jal x1,8
    add_vec(32'hFFFFF06F, mk(7'h6F, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 0)); // jal x0,-2
    add_vec(32'h40325213, mk(7'h13, 5, 7'h20, 4, 4, 0, 32'h3, 1, 1, 0, 0));    // srai x4,x4,3
    add_vec(32'h40321213, mk(7'h13, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));        // slli funct7=0x20
    add_vec(32'h00100073, mk(7'h73, 0, 0, 0, 0, 0, 32'h1, 0, 0, 0, 0));        // ebreak
    add_vec(32'h0FF0000F, mk(7'h0F, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));        // fence
`ifdef RV32M_DECODE_EN
    add_vec(32'h022081B3, mk(7'h33, 0, 7'h01, 3, 1, 2, 32'h0, 1, 1, 1, 0));    // mul x3,x1,x2
`else
    add_vec(32'h022081B3, mk(7'h33, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));        // mul without M
`endif

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));
    check("rst_fields", 128'(act), 128'(0));

    // First push: entry must appear one edge later.
    push_one(vecs[0]);
    check("latency_valid", 128'(out_valid), 128'(1'b1));
    check("latency_pc", 128'(out_pc), 128'(32'h100));
    out_ready = 1'b1;
    for (int i = 1; i < vecs.size(); i++) push_one(vecs[i]);
    wait_drain("table_drain");

    // Backpressure: fill, hold a fifth, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(vecs[i + 2]);
    check("full_in_ready", 128'(in_ready), 128'(1'b0));
    in_inst  = vecs[6].inst;
    in_pc    = next_pc;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("full_hold_ready", 128'(in_ready), 128'(1'b0));
      check("full_hold_head", 128'(out_pc), 128'(next_pc - 32'd16));
    end
    out_ready = 1'b1;
    push_one(vecs[6]);
    wait_drain("full_drain");
    check("full_ready_back", 128'(in_ready), 128'(1'b1));

    // Flush with three queued and an input offered in the flush cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(vecs[i]);
    in_inst  = vecs[3].inst;
    in_pc    = next_pc;
    cur_exp  = vecs[3].exp;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 128'(out_valid), 128'(1'b0));
    check("flush_ready", 128'(in_ready), 128'(1'b1));
    repeat (2) @(posedge clk);
    #1;
    check("flush_dropped", 128'(out_valid), 128'(1'b0));

    // Asynchronous reset between clock edges.
    push_one(vecs[0]);
    push_one(vecs[1]);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 128'(out_valid), 128'(1'b0));
    check("async_rst_ready", 128'(in_ready), 128'(1'b1));
    check("async_rst_fields", 128'(act), 128'(0));
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_one(vecs[2]);
    wait_drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
